// File: rtl/libcsr_pkg.sv
// Shared CSR definitions for the ORV32s machine-mode CSR block: operation and
// address encodings, controller states, field constants and the RMW helper.
package libcsr;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MTVAL     = 12'h343,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_MHARTID   = 12'hF14
  } csr_add_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRAP_SAVE   = 3'd1,
    ST_TRAP_STATUS = 3'd2,
    ST_TRAP_JUMP   = 3'd3,
    ST_MRET_STATUS = 3'd4,
    ST_MRET_JUMP   = 3'd5
  } csr_ctrl_state_e;

  localparam int unsigned MTVEC_MODE_BIT  = 0;
  localparam logic [1:0]  CSR_MSTATUS_MPP = 2'b11;

  function automatic logic [31:0] csr_apply_op(input csr_op_e op, input logic [31:0] old,
                                               input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old | wdata;
      CSR_OP_CLEAR: return old & ~wdata;
      default:      return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_counter64.sv
// 64-bit counter with per-half load; a load of either half wins over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] cnt_r;

  // Count register; a half-load suppresses the whole increment that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 64'd0;
    end else if (we_lo || we_hi) begin
      if (we_lo) cnt_r[31:0] <= wdata;
      if (we_hi) cnt_r[63:32] <= wdata;
    end else if (inc) begin
      cnt_r <= cnt_r + 64'd1;
    end
  end

  assign value = cnt_r;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR controller: trap CSRs, 64-bit cycle/instret counters,
// single-cycle CSR access and multi-cycle trap-entry / mret sequencing.
module csr_trap_ctrl
  import libcsr::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_req_i,
  input  csr_op_e         csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_gnt_o,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_req_i,
  output logic            ack_o,
  input  logic            instret_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o,
  output logic            mstatus_mie_o
);

  csr_ctrl_state_e state_r, state_nxt_s;
  logic [31:0] mtvec_r, mepc_r, mcause_r, mtval_r, mscratch_r;
  logic        mie_r, mpie_r;
  logic [63:0] mcycle_s, minstret_s;
  logic [31:0] old_s, new_s, tvec_base_s;
  logic        idle_s, exc_acc_s, mret_acc_s, gnt_s;
  logic        legal_s, ro_s, illegal_s, wr_req_s, do_write_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign exc_acc_s  = idle_s & exc_req_i;
  assign mret_acc_s = idle_s & mret_req_i & ~exc_req_i;
  assign gnt_s      = idle_s & csr_req_i & ~exc_req_i & ~mret_req_i;

  // Read mux and legality check for the addressed CSR
  always_comb begin
    old_s   = 32'd0;
    legal_s = 1'b1;
    ro_s    = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS:   old_s = {19'd0, CSR_MSTATUS_MPP, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};
      CSR_MISA:      begin old_s = MISA_VALUE; ro_s = 1'b1; end
      CSR_MTVEC:     old_s = mtvec_r;
      CSR_MSCRATCH:  old_s = mscratch_r;
      CSR_MEPC:      old_s = mepc_r;
      CSR_MCAUSE:    old_s = mcause_r;
      CSR_MTVAL:     old_s = mtval_r;
      CSR_MCYCLE:    old_s = mcycle_s[31:0];
      CSR_MCYCLEH:   old_s = mcycle_s[63:32];
      CSR_MINSTRET:  old_s = minstret_s[31:0];
      CSR_MINSTRETH: old_s = minstret_s[63:32];
      CSR_CYCLE:     begin old_s = mcycle_s[31:0]; ro_s = 1'b1; end
      CSR_MHARTID:   begin old_s = HART_ID; ro_s = 1'b1; end
      default:       legal_s = 1'b0;
    endcase
  end

  assign new_s      = csr_apply_op(csr_op_i, old_s, csr_wdata_i);
  assign illegal_s  = ~legal_s | (ro_s & (csr_op_i != CSR_OP_READ));
  // SET/CLEAR with a zero mask is a pure read and must not disturb the counters
  assign wr_req_s   = (csr_op_i == CSR_OP_WRITE) |
                      (((csr_op_i == CSR_OP_SET) | (csr_op_i == CSR_OP_CLEAR)) &
                       (csr_wdata_i != 32'd0));
  assign do_write_s = gnt_s & ~illegal_s & wr_req_s;

  // Trap/mret sequencing: fixed-length walk through the save/status/jump steps
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (exc_req_i)       state_nxt_s = ST_TRAP_SAVE;
        else if (mret_req_i) state_nxt_s = ST_MRET_STATUS;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_TRAP_SAVE:   state_nxt_s = ST_TRAP_STATUS;
      ST_TRAP_STATUS: state_nxt_s = ST_TRAP_JUMP;
      ST_MRET_STATUS: state_nxt_s = ST_MRET_JUMP;
      default:        state_nxt_s = ST_IDLE;
    endcase
  end

  // CSR state: trap capture at acceptance, status updates in the status steps, else CSR writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      mtvec_r    <= MTVEC_RESET;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
      mtval_r    <= 32'd0;
      mscratch_r <= 32'd0;
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (exc_acc_s) begin
        mepc_r   <= exc_pc_i & 32'hFFFF_FFFC;
        mcause_r <= exc_cause_i;
        mtval_r  <= exc_tval_i;
      end else if (do_write_s) begin
        case (csr_addr_i)
          CSR_MTVEC:    mtvec_r    <= new_s & 32'hFFFF_FFFD;
          CSR_MSCRATCH: mscratch_r <= new_s;
          CSR_MEPC:     mepc_r     <= new_s & 32'hFFFF_FFFC;
          CSR_MCAUSE:   mcause_r   <= new_s;
          CSR_MTVAL:    mtval_r    <= new_s;
          default:      ;
        endcase
      end
      if (state_r == ST_TRAP_STATUS) begin
        mpie_r <= mie_r;
        mie_r  <= 1'b0;
      end else if (state_r == ST_MRET_STATUS) begin
        mie_r  <= mpie_r;
        mpie_r <= 1'b1;
      end else if (do_write_s && (csr_addr_i == CSR_MSTATUS)) begin
        mie_r  <= new_s[3];
        mpie_r <= new_s[7];
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .we_lo (do_write_s && (csr_addr_i == CSR_MCYCLE)),
    .we_hi (do_write_s && (csr_addr_i == CSR_MCYCLEH)),
    .wdata (new_s),
    .value (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_i),
    .we_lo (do_write_s && (csr_addr_i == CSR_MINSTRET)),
    .we_hi (do_write_s && (csr_addr_i == CSR_MINSTRETH)),
    .wdata (new_s),
    .value (minstret_s)
  );

  // Fetch redirect driven purely from the registered state
  always_comb begin
    redirect_o    = 1'b0;
    redirect_pc_o = 32'd0;
    tvec_base_s   = {mtvec_r[31:2], 2'b00};
    case (state_r)
      ST_TRAP_JUMP: begin
        redirect_o = 1'b1;
        if (mtvec_r[MTVEC_MODE_BIT] && mcause_r[31])
          redirect_pc_o = tvec_base_s + {25'd0, mcause_r[4:0], 2'b00};
        else
          redirect_pc_o = tvec_base_s;
      end
      ST_MRET_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_r;
      end
      default: ;
    endcase
  end

  assign csr_gnt_o     = gnt_s;
  assign csr_rdata_o   = gnt_s ? old_s : 32'd0;
  assign csr_illegal_o = gnt_s & illegal_s;
  assign ack_o         = exc_acc_s | mret_acc_s;
  assign busy_o        = ~idle_s;
  assign mstatus_mie_o = mie_r;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed table, trap/mret sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_csr_trap_ctrl;
  import libcsr::*;

  localparam logic [31:0] HID  = 32'd3;
  localparam logic [31:0] MISA = 32'h4000_0100;
  localparam logic [31:0] TVR  = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_req, exc_req, mret_req, instret;
  csr_op_e     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, exc_cause, exc_pc, exc_tval;
  logic        csr_gnt_o, csr_illegal_o, ack_o, redirect_o, busy_o, mstatus_mie_o;
  logic [31:0] csr_rdata_o, redirect_pc_o;

  csr_trap_ctrl #(.XLEN(32), .HART_ID(HID), .MISA_VALUE(MISA), .MTVEC_RESET(TVR)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_gnt_o(csr_gnt_o), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc), .exc_tval_i(exc_tval),
    .mret_req_i(mret_req), .ack_o(ack_o), .instret_i(instret),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o), .mstatus_mie_o(mstatus_mie_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_tgt;
  logic        m_mie, m_mpie;
  logic [63:0] m_cyc, m_ins;
  int          m_busy;

  typedef struct {
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
  } vec_t;
  vec_t tbl [0:23];

  logic [11:0] addrs [0:13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hF14, 12'h344};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtvec = TVR; m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0; m_mscratch = 32'd0;
    m_mie = 1'b0; m_mpie = 1'b0; m_cyc = 64'd0; m_ins = 64'd0; m_busy = 0; m_tgt = 32'd0;
  endtask

  function automatic void m_read(input logic [11:0] a, output logic ok, output logic ro,
                                 output logic [31:0] v);
    ok = 1'b1; ro = 1'b0; v = 32'd0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: begin v = MISA; ro = 1'b1; end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hC00: begin v = m_cyc[31:0]; ro = 1'b1; end
      12'hF14: begin v = HID; ro = 1'b1; end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic model_check();
    logic ok, ro, ill, idle, e_gnt;
    logic [31:0] v;
    idle  = (m_busy == 0);
    e_gnt = idle & csr_req & ~exc_req & ~mret_req;
    chk("gnt", {31'd0, csr_gnt_o}, {31'd0, e_gnt});
    chk("ack", {31'd0, ack_o}, {31'd0, idle & (exc_req | mret_req)});
    chk("busy", {31'd0, busy_o}, {31'd0, !idle});
    chk("redirect", {31'd0, redirect_o}, {31'd0, m_busy == 1});
    if (m_busy == 1) chk("redirect_pc", redirect_pc_o, m_tgt);
    if (idle) chk("mie", {31'd0, mstatus_mie_o}, {31'd0, m_mie});
    if (e_gnt) begin
      m_read(csr_addr, ok, ro, v);
      ill = !ok || (ro && csr_op != CSR_OP_READ);
      chk("illegal", {31'd0, csr_illegal_o}, {31'd0, ill});
      if (!ill) chk("rdata", csr_rdata_o, v);
    end
  endtask

  task automatic model_update();
    logic ok, ro, wr, idle;
    logic [31:0] v, nv;
    if (!rst_n) begin
      model_reset();
    end else begin
      idle = (m_busy == 0);
      wr = 1'b0; nv = 32'd0;
      if (idle && csr_req && !exc_req && !mret_req) begin
        m_read(csr_addr, ok, ro, v);
        wr = ok && !(ro && csr_op != CSR_OP_READ) &&
             (csr_op == CSR_OP_WRITE || (csr_op != CSR_OP_READ && csr_wdata != 32'd0));
        if (csr_op == CSR_OP_WRITE)    nv = csr_wdata;
        else if (csr_op == CSR_OP_SET) nv = v | csr_wdata;
        else                           nv = v & ~csr_wdata;
      end
      if (wr && csr_addr == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
      else if (wr && csr_addr == 12'hB80) m_cyc = {nv, m_cyc[31:0]};
      else                                m_cyc = m_cyc + 64'd1;
      if (wr && csr_addr == 12'hB02)      m_ins = {m_ins[63:32], nv};
      else if (wr && csr_addr == 12'hB82) m_ins = {nv, m_ins[31:0]};
      else if (instret)                   m_ins = m_ins + 64'd1;
      if (wr) begin
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec = nv & ~32'd2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'd3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          default: ;
        endcase
      end
      if (idle && exc_req) begin
        m_mepc = exc_pc & ~32'd3; m_mcause = exc_cause; m_mtval = exc_tval;
        m_mpie = m_mie; m_mie = 1'b0;
        m_tgt = m_mtvec & ~32'd3;
        if (m_mtvec[0] && exc_cause[31]) m_tgt = m_tgt + 32'd4 * (exc_cause % 32);
        m_busy = 3;
      end else if (idle && mret_req) begin
        m_mie = m_mpie; m_mpie = 1'b1; m_tgt = m_mepc; m_busy = 2;
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
  endtask

  task automatic tick();
    #1;
    if (!rst_n) model_reset();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic csr_acc(input csr_op_e op, input logic [11:0] a, input logic [31:0] d);
    csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    csr_req = 1'b0; csr_op = CSR_OP_READ; csr_wdata = 32'd0;
  endtask

  task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_req = 1'b1; csr_op = CSR_OP_READ; csr_addr = a; csr_wdata = 32'd0;
    #1;
    chk(nm, csr_rdata_o, exp);
    tick();
    csr_req = 1'b0;
  endtask

  task automatic wait_redirect(input int exp_lat, input logic [31:0] exp_pc, input string nm);
    int found = 0;
    logic [31:0] pcv = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (redirect_o && found == 0) begin found = k; pcv = redirect_pc_o; end
      tick();
      if (found != 0) break;
    end
    chk({nm, "_lat"}, found, exp_lat);
    chk({nm, "_pc"}, pcv, exp_pc);
  endtask

  task automatic do_trap(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv,
                         input logic [31:0] exp_pc, input string nm);
    exc_req = 1'b1; exc_cause = c; exc_pc = pc; exc_tval = tv;
    #1;
    chk({nm, "_ack"}, {31'd0, ack_o}, 32'd1);
    tick();
    exc_req = 1'b0;
    wait_redirect(3, exp_pc, nm);
  endtask

  initial begin
    logic acc_e, acc_m;
    int   found;
    tbl[0]  = '{CSR_OP_READ,  12'h305, 32'h0,         32'h0000_0040, 1'b0};
    tbl[1]  = '{CSR_OP_READ,  12'h300, 32'h0,         32'h0000_1800, 1'b0};
    tbl[2]  = '{CSR_OP_READ,  12'hF14, 32'h0,         32'h0000_0003, 1'b0};
    tbl[3]  = '{CSR_OP_READ,  12'h301, 32'h0,         32'h4000_0100, 1'b0};
    tbl[4]  = '{CSR_OP_WRITE, 12'h301, 32'h0,         32'h0,         1'b1};
    tbl[5]  = '{CSR_OP_READ,  12'h301, 32'h0,         32'h4000_0100, 1'b0};
    tbl[6]  = '{CSR_OP_WRITE, 12'h305, 32'h103,       32'h0000_0040, 1'b0};
    tbl[7]  = '{CSR_OP_READ,  12'h305, 32'h0,         32'h0000_0101, 1'b0};
    tbl[8]  = '{CSR_OP_SET,   12'h300, 32'h8,         32'h0000_1800, 1'b0};
    tbl[9]  = '{CSR_OP_READ,  12'h300, 32'h0,         32'h0000_1808, 1'b0};
    tbl[10] = '{CSR_OP_CLEAR, 12'h300, 32'h0,         32'h0000_1808, 1'b0};
    tbl[11] = '{CSR_OP_READ,  12'h300, 32'h0,         32'h0000_1808, 1'b0};
    tbl[12] = '{CSR_OP_WRITE, 12'h341, 32'h2003,      32'h0,         1'b0};
    tbl[13] = '{CSR_OP_READ,  12'h341, 32'h0,         32'h0000_2000, 1'b0};
    tbl[14] = '{CSR_OP_WRITE, 12'h7C0, 32'h1,         32'h0,         1'b1};
    tbl[15] = '{CSR_OP_READ,  12'h344, 32'h0,         32'h0,         1'b1};
    tbl[16] = '{CSR_OP_SET,   12'h340, 32'hF0,        32'h0,         1'b0};
    tbl[17] = '{CSR_OP_CLEAR, 12'h340, 32'h30,        32'h0000_00F0, 1'b0};
    tbl[18] = '{CSR_OP_READ,  12'h340, 32'h0,         32'h0000_00C0, 1'b0};
    tbl[19] = '{CSR_OP_WRITE, 12'hC00, 32'h5,         32'h0,         1'b1};
    tbl[20] = '{CSR_OP_SET,   12'hF14, 32'h0,         32'h0,         1'b1};
    tbl[21] = '{CSR_OP_WRITE, 12'h300, 32'hFFFF_FFFF, 32'h0000_1808, 1'b0};
    tbl[22] = '{CSR_OP_READ,  12'h300, 32'h0,         32'h0000_1888, 1'b0};
    tbl[23] = '{CSR_OP_WRITE, 12'h305, 32'h100,       32'h0000_0101, 1'b0};

    rst_n = 1'b0; csr_req = 1'b0; exc_req = 1'b0; mret_req = 1'b0; instret = 1'b0;
    csr_op = CSR_OP_READ; csr_addr = 12'h0; csr_wdata = 32'd0;
    exc_cause = 32'd0; exc_pc = 32'd0; exc_tval = 32'd0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      csr_req = 1'b1; csr_op = tbl[i].op; csr_addr = tbl[i].addr; csr_wdata = tbl[i].wdata;
      #1;
      chk($sformatf("tbl%0d_gnt", i), {31'd0, csr_gnt_o}, 32'd1);
      chk($sformatf("tbl%0d_ill", i), {31'd0, csr_illegal_o}, {31'd0, tbl[i].ill});
      if (!tbl[i].ill) chk($sformatf("tbl%0d_rdata", i), csr_rdata_o, tbl[i].rdata);
      tick();
    end
    csr_req = 1'b0;

    do_trap(32'd2, 32'h2002, 32'hDEAD, 32'h100, "trap_exc");
    csr_rd(12'h341, 32'h2000, "mepc");
    csr_rd(12'h342, 32'h2, "mcause");
    csr_rd(12'h343, 32'hDEAD, "mtval");
    csr_rd(12'h300, 32'h1880, "mstatus_trap");

    mret_req = 1'b1;
    #1;
    chk("mret_ack", {31'd0, ack_o}, 32'd1);
    tick();
    mret_req = 1'b0;
    wait_redirect(2, 32'h2000, "mret");
    csr_rd(12'h300, 32'h1888, "mstatus_mret");

    csr_acc(CSR_OP_WRITE, 12'h305, 32'h101);
    do_trap(32'h8000_0007, 32'h3000, 32'h0, 32'h11C, "trap_irq");

    // simultaneous exc, mret and csr: exc wins, mret waits for the next IDLE
    exc_req = 1'b1; mret_req = 1'b1; csr_req = 1'b1; csr_op = CSR_OP_READ; csr_addr = 12'h305;
    exc_cause = 32'd5; exc_pc = 32'h404; exc_tval = 32'd0;
    #1;
    chk("prio_ack", {31'd0, ack_o}, 32'd1);
    chk("prio_gnt", {31'd0, csr_gnt_o}, 32'd0);
    tick();
    exc_req = 1'b0; csr_req = 1'b0;
    found = 0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (ack_o && found == 0) found = k;
      tick();
      if (found != 0) break;
    end
    mret_req = 1'b0;
    chk("prio_mret_lat", found, 32'd4);
    wait_redirect(2, 32'h404, "prio_mret");

    csr_acc(CSR_OP_WRITE, 12'hB00, 32'hFFFF_FFFF);
    tick();
    csr_rd(12'hB80, 32'd1, "mcycleh_wrap");

    // reset in the middle of a trap sequence
    exc_req = 1'b1; exc_cause = 32'd1; exc_pc = 32'h10; exc_tval = 32'd0;
    tick();
    exc_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_redirect", {31'd0, redirect_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    csr_rd(12'h305, TVR, "rst_mtvec");
    csr_rd(12'h341, 32'd0, "rst_mepc");

    for (int it = 0; it < 600; it++) begin
      csr_req   = ($urandom_range(0, 1) == 1);
      csr_op    = csr_op_e'($urandom_range(0, 3));
      csr_addr  = addrs[$urandom_range(0, 13)];
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      instret   = ($urandom_range(0, 1) == 1);
      if (!exc_req && $urandom_range(0, 15) == 0) begin
        exc_req = 1'b1; exc_cause = $urandom; exc_pc = $urandom; exc_tval = $urandom;
      end
      if (!mret_req && $urandom_range(0, 11) == 0) mret_req = 1'b1;
      acc_e = (m_busy == 0) && exc_req;
      acc_m = (m_busy == 0) && !exc_req && mret_req;
      tick();
      if (acc_e) exc_req = 1'b0;
      if (acc_m) mret_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode CSR controller for the ORV32s core. It owns the machine trap CSRs and the cycle/instret counters, and serves single-cycle CSR instruction accesses from the execute stage. It sequences trap entry and `mret` as multi-cycle operations that update mepc/mcause/mtval/mstatus and redirect fetch. Exceptions, `mret` and CSR instructions are arbitrated with fixed priority.

## Interface
Parameters:
- `XLEN`, 32, data width (only 32 supported)
- `HART_ID`, 0, value read from mhartid
- `MISA_VALUE`, 32'h4000_0100, value read from misa (RV32I)
- `MTVEC_RESET`, 32'h0000_0000, reset value of mtvec

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `rst_n` in 1: async active-low reset
- `csr_req_i` in 1: CSR instruction access request
- `csr_op_i` in 2: `csr_op_e`
- `csr_addr_i` in 12: `csr_add_e` address
- `csr_wdata_i` in 32: operand
- `csr_gnt_o` out 1: access performed this cycle
- `csr_rdata_o` out 32: old CSR value, valid when `csr_gnt_o`
- `csr_illegal_o` out 1: access rejected, valid when `csr_gnt_o`
- `exc_req_i` in 1: trap request, held until ack
- `exc_cause_i` in 32: mcause value; bit31 marks an interrupt
- `exc_pc_i` in 32: faulting pc
- `exc_tval_i` in 32: mtval value
- `mret_req_i` in 1: mret request, held until ack
- `ack_o` out 1: exc/mret accepted (1-cycle pulse)
- `instret_i` in 1: instruction retired this cycle
- `redirect_o` out 1: fetch redirect pulse
- `redirect_pc_o` out 32: redirect target
- `busy_o` out 1: high in any non-IDLE state
- `mstatus_mie_o` out 1: global interrupt enable

## Operation
- States: IDLE, TRAP_SAVE, TRAP_STATUS, TRAP_JUMP, MRET_STATUS, MRET_JUMP.
- IDLE priority: exc_req_i > mret_req_i > csr_req_i. `ack_o` pulses on exc/mret acceptance.
- Trap accepted → TRAP_SAVE.
  - TRAP_SAVE: mepc ← {pc[31:2],00}, mcause ← cause, mtval ← tval.
  - TRAP_STATUS: MPIE ← MIE, MIE ← 0.
  - TRAP_JUMP: `redirect_o`=1. Target is {mtvec[31:2],00}. If mtvec[0]=1 (vectored) and cause[31]=1, target is base + 4·cause[4:0]. Then → IDLE.
- mret accepted → MRET_STATUS: MIE ← MPIE, MPIE ← 1. MRET_JUMP: `redirect_o`=1, target = mepc. Then → IDLE.
- Requests arriving outside IDLE are ignored; requesters hold them until acked.
- CSR access:
  - `csr_gnt_o` = csr_req_i & IDLE & !exc_req_i & !mret_req_i.
  - `csr_rdata_o` is combinational.
  - New value by op: WRITE = wdata; SET = old|wdata; CLEAR = old&~wdata. SET/CLEAR with wdata=0 perform no write.
- Writable fields:
  - mstatus: MIE, MPIE only. MPP reads 2'b11; all other bits read 0.
  - mepc: bits[1:0] forced 0.
  - mtvec: bit1 forced 0.
  - mscratch, mcause, mtval: fully writable.
- Illegal (`csr_illegal_o`=1, no state change): unlisted address; any write, SET or CLEAR to mhartid, misa or cycle. CSR_OP_READ of a read-only CSR is legal.
- Counters (64-bit):
  - mcycle +1 every cycle; minstret +1 when instret_i.
  - A write to the low or high half replaces that half in the same cycle it would increment; the increment is dropped for that cycle.
  - mcycle/mcycleh/cycle read the halves; minstret/minstreth likewise.

## Timing
- Reset: all CSRs 0 except mtvec = MTVEC_RESET. State IDLE; all outputs 0.
- CSR write is visible on the next cycle's read.
- Trap: accept at cycle N (ack_o), redirect_o at N+3, `busy_o` high N+1..N+3, next acceptance at N+4.
- mret: accept at N, redirect at N+2.
- Counters increment during busy states.
- Low-half wrap 32'hFFFF_FFFF → 0 carries into the high half.
- Reset mid-sequence returns to IDLE immediately; no partial redirect.

## Structure
- Add to libcsr:
  - `csr_ctrl_state_e` enum
  - MTVEC mode bit index (0)
  - CSR_MSTATUS_MPP reset constant 2'b11
- Sub-module `csr_counter64`: 64-bit counter with increment enable, per-half write enable and write-over-increment priority. Instantiated twice.

## Test plan
- Reset release, then read mtvec, mstatus, mhartid → MTVEC_RESET, 0x0000_1800, HART_ID; illegal=0.
- mtvec=0x100, MIE=1; exception cause 2, pc 0x2002, tval 0xDEAD → redirect 0x100 at N+3; mepc=0x2000, mcause=2, mtval=0xDEAD; mstatus=0x1880.
- mtvec=0x101; interrupt cause 0x8000_0007 → redirect 0x11C.
- After the trap, mret → redirect to mepc at N+2; MIE=1, MPIE=1.
- exc_req_i, mret_req_i and csr_req_i in the same cycle → exc acked; csr_gnt_o=0; mret acked 4 cycles later.
- Write mcycle=0xFFFF_FFFF, then read mcycleh 2 cycles later → 1.
- Write to misa → illegal=1, value unchanged.
- CLEAR mstatus with wdata=0 → no change.
